// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with iterative shift-add multiply and restoring divide.
// Optional divider built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             Err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_start_mul;
    logic [WIDTH-1:0] w_res;
    logic             w_res_c;
    logic             w_res_e;
    logic [WIDTH:0]   w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_prod;

    assign In_Ready    = (r_state == S_IDLE);
    assign Out_Valid   = (r_state == S_DONE);
    assign ALU_Out     = r_out;
    assign CarryOut    = r_carry;
    assign Err         = r_err;
    assign w_accept    = In_Valid && In_Ready;
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    assign w_start_mul = (ALU_Sel == 4'b0010);

    // Product register is {r_hi, r_lo}: accumulator on top, multiplier shifting out below.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_prod = {w_mul_sum, r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic             w_start_div;
    logic [WIDTH:0]   w_div_sh;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    // Remainder in r_hi, dividend shifting out of r_lo while quotient bits shift in.
    assign w_start_div = (ALU_Sel == 4'b0011) && (B != '0);
    assign w_div_sh    = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_sh >= {1'b0, r_b});
    assign w_div_diff  = w_div_sh[WIDTH-1:0] - r_b;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
    assign w_div_quo   = {r_lo[WIDTH-2:0], w_div_ge};
`endif

    always_comb begin
        w_res   = '0;
        w_res_c = 1'b0;
        w_res_e = 1'b0;
        case (ALU_Sel)
            4'b0000: {w_res_c, w_res} = {1'b0, A} + {1'b0, B};
            4'b0001: begin
                w_res   = A - B;
                w_res_c = (A < B);
            end
            // Reached only for a zero divisor, or always when the divider is absent.
            4'b0011: begin
                w_res   = '1;
                w_res_e = 1'b1;
            end
            4'b0100: w_res = {A[WIDTH-2:0], 1'b0};
            4'b0101: w_res = {1'b0, A[WIDTH-1:1]};
            4'b0110: w_res = {A[WIDTH-2:0], A[WIDTH-1]};
            4'b0111: w_res = {A[0], A[WIDTH-1:1]};
            4'b1000: w_res = A & B;
            4'b1001: w_res = A | B;
            4'b1010: w_res = A ^ B;
            4'b1011: w_res = ~(A | B);
            4'b1100: w_res = ~(A & B);
            4'b1101: w_res = ~(A ^ B);
            4'b1110: w_res = {{(WIDTH-1){1'b0}}, (A > B)};
            4'b1111: w_res = {{(WIDTH-1){1'b0}}, (A == B)};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_start_mul) begin
                        w_next = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    end else if (w_start_div) begin
                        w_next = S_DIV;
`endif
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (w_last) begin
                    w_next = S_DONE;
                end
`else
                w_next = S_IDLE;
`endif
            end
            S_DONE: begin
                if (Out_Ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hi  <= '0;
                        r_lo  <= A;
                        r_b   <= B;
                        r_cnt <= '0;
                        if (w_next == S_DONE) begin
                            r_out   <= w_res;
                            r_carry <= w_res_c;
                            r_err   <= w_res_e;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + CW'(1);
                    {r_hi, r_lo} <= w_mul_prod;
                    if (w_last) begin
                        r_out   <= w_mul_prod[WIDTH-1:0];
                        r_carry <= |w_mul_prod[2*WIDTH-1:WIDTH];
                        r_err   <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    r_cnt <= r_cnt + CW'(1);
                    r_hi  <= w_div_rem;
                    r_lo  <= w_div_quo;
                    if (w_last) begin
                        r_out   <= w_div_quo;
                        r_carry <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ALU_Sel = '0;
    logic         Out_Valid;
    logic         Out_Ready = 1'b1;
    logic [W-1:0] ALU_Out;
    logic         CarryOut;
    logic         Err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit bp_force = 1'b0;
    bit rand_rdy = 1'b0;
    bit seen = 1'b0;

    typedef struct {
        logic [W-1:0] out;
        logic         c;
        logic         e;
        int           lat;
        int           vcyc;
    } exp_t;

    exp_t q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Err(Err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_force) Out_Ready = 1'b0;
        else if (rand_rdy) Out_Ready = ($urandom_range(0, 2) != 0);
        else Out_Ready = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on wide unsigned integers; lat is cycles from the accept edge.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint unsigned mask = (64'd1 << W) - 1;
        longint unsigned r = 0;
        e.c = 1'b0; e.e = 1'b0; e.lat = 0; e.vcyc = 0;
        case (op)
            4'd0: begin r = ua + ub; e.c = ((r >> W) & 1) != 0; end
            4'd1: begin r = ua - ub; e.c = (ua < ub); end
            4'd2: begin r = ua * ub; e.c = (r >> W) != 0; e.lat = W; end
            4'd3: begin
`ifdef ALU_SEQ_DIV_EN
                if (ub == 0) begin r = mask; e.e = 1'b1; end
                else begin r = ua / ub; e.lat = W; end
`else
                r = mask; e.e = 1'b1;
`endif
            end
            4'd4: r = ua << 1;
            4'd5: r = ua >> 1;
            4'd6: r = (ua << 1) | (ua >> (W - 1));
            4'd7: r = (ua >> 1) | ((ua & 1) << (W - 1));
            4'd8: r = ua & ub;
            4'd9: r = ua | ub;
            4'd10: r = ua ^ ub;
            4'd11: r = ~(ua | ub);
            4'd12: r = ~(ua & ub);
            4'd13: r = ~(ua ^ ub);
            4'd14: r = (ua > ub) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        e.out = W'(r & mask);
        return e;
    endfunction

    // Monitor: compares every cycle a result is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            seen = 1'b0;
        end else if (Out_Valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'(Out_Valid), 64'd0);
            end else begin
                chk("alu_out", 64'(ALU_Out), 64'(q[0].out));
                chk("carry_out", 64'(CarryOut), 64'(q[0].c));
                chk("err", 64'(Err), 64'(q[0].e));
                chk("in_ready_while_done", 64'(In_Ready), 64'd0);
                if (!seen) chk("latency_cycle", 64'(cyc), 64'(q[0].vcyc));
                seen = 1'b1;
                if (Out_Ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int t = 0;
        while (!In_Ready && t < 500) begin
            @(posedge clk); #1; t++;
        end
        if (!In_Ready) begin
            chk("in_ready_timeout", 64'(In_Ready), 64'd1);
            return;
        end
        ALU_Sel = op; A = a; B = b; In_Valid = 1'b1;
        @(posedge clk); #1;
        e = model(op, a, b);
        e.vcyc = cyc + e.lat;
        q.push_back(e);
        In_Valid = 1'b0;
        A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || Out_Valid) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(In_Ready), 64'd1);
        chk("reset_out_valid", 64'(Out_Valid), 64'd0);
        chk("reset_alu_out", 64'(ALU_Out), 64'd0);
        chk("reset_carry", 64'(CarryOut), 64'd0);
        chk("reset_err", 64'(Err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_in_ready", 64'(In_Ready), 64'd1);

        issue(4'b0000, 8'hF0, 8'h20);
        drain();

        issue(4'b0010, 8'd20, 8'd13);
        for (int i = 0; i < W; i++) begin
            chk("mul_in_ready_low", 64'(In_Ready), 64'd0);
            chk("mul_out_valid_low", 64'(Out_Valid), 64'd0);
            @(posedge clk); #1;
        end
        drain();

`ifdef ALU_SEQ_DIV_EN
        issue(4'b0011, 8'd200, 8'd7);
        drain();
        issue(4'b0011, 8'd200, 8'd0);
        drain();
`else
        issue(4'b0011, 8'd9, 8'd3);
        drain();
`endif

        bp_force = 1'b1;
        @(posedge clk); #1;
        issue(4'b0001, 8'd3, 8'd5);
        for (int i = 0; i < 10; i++) begin
            In_Valid = (i % 2) == 0;
            A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
            @(posedge clk); #1;
        end
        In_Valid = 1'b0;
        bp_force = 1'b0;
        drain();

        issue(4'b0010, 8'd250, 8'd251);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(Out_Valid), 64'd0);
        chk("abort_alu_out", 64'(ALU_Out), 64'd0);
        chk("abort_carry", 64'(CarryOut), 64'd0);
        chk("abort_err", 64'(Err), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", 64'(In_Ready), 64'd1);
        issue(4'b0000, 8'd100, 8'd27);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 4'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) b = a;
            issue(op, a, b);
        end
        for (int op = 0; op < 16; op++) begin
            issue(4'(op), 8'hFF, 8'hFF);
            issue(4'(op), 8'h80, 8'h01);
        end
        drain();
        rand_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 In_Valid  input  1  operand/opcode presented.
REQ-005 In_Ready  output  1  block can accept a new operation.
REQ-006 A, B  input  WIDTH each  operands, unsigned.
REQ-007 ALU_Sel  input  4  opcode.
REQ-008 Out_Valid  output  1  result available.
REQ-009 Out_Ready  input  1  consumer takes result.
REQ-010 ALU_Out  output  WIDTH  result.
REQ-011 CarryOut  output  1  carry/borrow/overflow flag.
REQ-012 Err  output  1  division by zero, or unsupported op.

Function
REQ-013 Opcodes: 0000 A+B; 0001 A-B; 0010 A*B; 0011 A/B; 0100 A<<1; 0101 A>>1; 0110 rotl1; 0111 rotr1; 1000 AND; 1001 OR; 1010 XOR; 1011 NOR; 1100 NAND; 1101 XNOR; 1110 (A>B)?1:0; 1111 (A==B)?1:0.
REQ-014 FSM states IDLE, MUL, DIV, DONE; In_Ready=1 only in IDLE.
REQ-015 Accept on rising edge with In_Valid&&In_Ready; A, B, ALU_Sel captured, later input changes ignored.
REQ-016 Single-cycle ops (all except 0010/0011): IDLE->DONE; Out_Valid high the cycle after accept.
REQ-017 0010: iterative shift-add, IDLE->MUL, exactly WIDTH cycles in MUL, then DONE; Out_Valid at accept+WIDTH+1.
REQ-018 0011: restoring division, IDLE->DIV, exactly WIDTH cycles in DIV, then DONE; same latency as MUL.
REQ-019 ALU_Out/CarryOut/Err stable while Out_Valid=1; DONE->IDLE on edge with Out_Ready=1; no new accept in that same cycle.
REQ-020 Out_Valid held indefinitely while Out_Ready=0 (back-pressure).
REQ-021 Width: add CarryOut = bit WIDTH of (WIDTH+1)-bit sum; sub CarryOut = borrow (A<B); mul ALU_Out = low WIDTH bits, CarryOut = OR of high WIDTH bits; all other ops CarryOut=0.
REQ-022 Shifts fill zero; rotates wrap MSB<->LSB; compare results zero-extended to WIDTH.
REQ-023 Divide by zero: no DIV iteration, IDLE->DONE in one cycle, ALU_Out all ones, Err=1.
REQ-024 Err=0 for every other completed op (with ALU_SEQ_DIV_EN defined).

Reset
REQ-025 rst_n low: state IDLE immediately; In_Ready=1 after deassert; Out_Valid=0, ALU_Out=0, CarryOut=0, Err=0.
REQ-026 rst_n asserted mid-MUL/DIV/DONE aborts op; no Out_Valid produced for it.

Configuration
REQ-027 Macro ALU_SEQ_DIV_EN: defined -> divider and DIV state built, REQ-018/023 apply.
REQ-028 Undefined -> no divider logic; 0011 completes single-cycle, ALU_Out all ones, Err=1, CarryOut=0.

Verification (WIDTH=8)
REQ-029 0000 A=8'hF0 B=8'h20 -> one cycle later Out_Valid, ALU_Out=8'h10, CarryOut=1, Err=0.
REQ-030 0010 A=8'd20 B=8'd13 -> Out_Valid exactly 9 cycles after accept, ALU_Out=8'h04, CarryOut=1; In_Ready=0 throughout.
REQ-031 0011 A=8'd200 B=8'd7 -> 9 cycles, ALU_Out=8'd28; then B=0 -> 1 cycle, ALU_Out=8'hFF, Err=1.
REQ-032 0001 A=8'd3 B=8'd5, Out_Ready=0 for 10 cycles -> ALU_Out=8'hFE, CarryOut=1 held stable; In_Valid pulses ignored.
REQ-033 Start 0010, drop rst_n on 4th MUL cycle -> outputs zero immediately, no Out_Valid, next op correct.
REQ-034 Build without ALU_SEQ_DIV_EN, 0011 A=8'd9 B=8'd3 -> one cycle, ALU_Out=8'hFF, Err=1.
